// File: rtl/gmii_tx_pkg.sv
// Shared types and constants for the GMII frame transmit path and its CRC32 step.
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  localparam int unsigned PREAMBLE_LEN   = 7;

  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY       = 32'hEDB8_8320;

  localparam int unsigned IFG_CYCLES_DEF = 12;

endpackage

// File: rtl/crc32_d8.sv
// Ethernet CRC32 (reflected), one byte per enabled cycle; register holds the
// running remainder, the caller applies the final inversion.
module crc32_d8
  import gmii_tx_pkg::*;
(
  input  logic        rd_clk,
  input  logic        rst_n,
  input  logic        crc_init,
  input  logic        crc_en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  always_comb begin
    crc_next = crc ^ {24'h0, data};
    for (int unsigned i = 0; i < 8; i++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (crc_init) begin
      crc <= CRC_INIT;
    end else if (crc_en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/gmii_frame_tx.sv
// GMII frame transmitter: preamble/SFD, buffered payload, optional zero pad,
// CRC32 FCS and inter-frame gap. Padding compiled in with GMII_FRAME_TX_PAD_EN.
module gmii_frame_tx
  import gmii_tx_pkg::*;
#(
  parameter int unsigned MAX_BYTES   = 1500,
  parameter int unsigned IFG_CYCLES  = IFG_CYCLES_DEF,
  parameter int unsigned MIN_PAYLOAD = 46
) (
  input  logic        rd_clk,
  input  logic        rst_n,
  input  logic        tx_start_en,
  input  logic [15:0] tx_byte_num,
  output logic        tx_req,
  input  logic [7:0]  tx_data,
  output logic        tx_done,
  output logic        tx_busy,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd
);

  localparam logic [15:0] MAX_N    = 16'(MAX_BYTES);
  localparam logic [3:0]  PRE_LAST = 4'(PREAMBLE_LEN - 1);
  localparam logic [3:0]  IFG_LAST = 4'(IFG_CYCLES - 1);
`ifdef GMII_FRAME_TX_PAD_EN
  localparam logic [15:0] PAD_MIN  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] PAD_LAST = 16'(MIN_PAYLOAD - 1);
`endif

  if (MIN_PAYLOAD > MAX_BYTES || IFG_CYCLES < 1 || IFG_CYCLES > 16 ||
      MAX_BYTES < 1 || MAX_BYTES > 65535) begin : g_bad_cfg
    $error("gmii_frame_tx: unsupported parameter set");
  end

  tx_state_t   state, state_next;
  logic [15:0] n_q, n_next;
  logic [15:0] cnt_q, cnt_next;
  logic [3:0]  phase_q, phase_next;
  logic        crc_init, crc_en;
  logic [7:0]  crc_data;
  logic [31:0] crc_q, fcs;
  logic        en_next, done_next, busy_next, last_byte;
  logic [7:0]  txd_next;

  crc32_d8 u_crc (
    .rd_clk   (rd_clk),
    .rst_n    (rst_n),
    .crc_init (crc_init),
    .crc_en   (crc_en),
    .data     (crc_data),
    .crc      (crc_q)
  );

  // FSM state in cycle c selects what lands on the GMII register at edge c+1;
  // tx_req leads the payload by one cycle so tx_data is valid in PAYLOAD.
  always_comb begin
    state_next = state;
    n_next     = n_q;
    cnt_next   = cnt_q;
    phase_next = phase_q;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    crc_data   = tx_data;
    en_next    = 1'b0;
    txd_next   = '0;
    done_next  = 1'b0;
    tx_req     = 1'b0;
    last_byte  = (cnt_q == n_q - 16'd1);
    fcs        = ~crc_q;

    unique case (state)
      ST_IDLE: begin
        if (tx_start_en && !tx_busy) begin
          n_next     = (tx_byte_num > MAX_N) ? MAX_N : tx_byte_num;
          cnt_next   = '0;
          phase_next = '0;
          crc_init   = 1'b1;
          state_next = (n_next == '0) ? ST_IFG : ST_PREAMBLE;
        end
      end
      ST_PREAMBLE: begin
        en_next    = 1'b1;
        txd_next   = PREAMBLE_BYTE;
        phase_next = phase_q + 4'd1;
        if (phase_q == PRE_LAST) state_next = ST_SFD;
      end
      ST_SFD: begin
        en_next    = 1'b1;
        txd_next   = SFD_BYTE;
        tx_req     = 1'b1;
        state_next = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        en_next  = 1'b1;
        txd_next = tx_data;
        crc_en   = 1'b1;
        cnt_next = cnt_q + 16'd1;
        tx_req   = !last_byte;
        if (last_byte) begin
          phase_next = '0;
`ifdef GMII_FRAME_TX_PAD_EN
          state_next = (n_q < PAD_MIN) ? ST_PAD : ST_FCS;
`else
          state_next = ST_FCS;
`endif
        end
      end
`ifdef GMII_FRAME_TX_PAD_EN
      ST_PAD: begin
        en_next  = 1'b1;
        txd_next = '0;
        crc_data = '0;
        crc_en   = 1'b1;
        cnt_next = cnt_q + 16'd1;
        if (cnt_q == PAD_LAST) state_next = ST_FCS;
      end
`endif
      ST_FCS: begin
        en_next    = 1'b1;
        txd_next   = fcs[{phase_q[1:0], 3'b000} +: 8];
        phase_next = phase_q + 4'd1;
        if (phase_q == 4'd3) begin
          phase_next = '0;
          state_next = ST_IFG;
        end
      end
      ST_IFG: begin
        phase_next = phase_q + 4'd1;
        if (phase_q == IFG_LAST) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE) || done_next;
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      n_q        <= '0;
      cnt_q      <= '0;
      phase_q    <= '0;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
      tx_done    <= 1'b0;
      tx_busy    <= 1'b0;
    end else begin
      state      <= state_next;
      n_q        <= n_next;
      cnt_q      <= cnt_next;
      phase_q    <= phase_next;
      gmii_tx_en <= en_next;
      gmii_txd   <= txd_next;
      tx_done    <= done_next;
      tx_busy    <= busy_next;
    end
  end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Directed bench for gmii_frame_tx: timeline, CRC, clamp, zero length,
// back-to-back starts, mid-frame reset and (when compiled in) padding.
`timescale 1ns/1ps
module tb_gmii_frame_tx;

  logic        rd_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_start_en = 1'b0;
  logic [15:0] tx_byte_num = '0;
  logic        tx_req;
  logic [7:0]  tx_data = '0;
  logic        tx_done, tx_busy, gmii_tx_en;
  logic [7:0]  gmii_txd;

  always #4 rd_clk = ~rd_clk;

  gmii_frame_tx #(.MAX_BYTES(1500), .IFG_CYCLES(12), .MIN_PAYLOAD(46)) dut (
    .rd_clk      (rd_clk),
    .rst_n       (rst_n),
    .tx_start_en (tx_start_en),
    .tx_byte_num (tx_byte_num),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .tx_busy     (tx_busy),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd)
  );

  int errors = 0;
  int checks = 0;

  // Buffer model: data one cycle after each request, junk otherwise.
  logic [7:0] mem [0:2047];
  int rd_ptr = 0;
  always @(posedge rd_clk) begin
    if (!tx_busy) rd_ptr <= 0;
    else if (tx_req) rd_ptr <= rd_ptr + 1;
    tx_data <= tx_req ? mem[rd_ptr] : 8'hA5;
  end

  int req_cnt, req_first, req_last, en_cnt, en_first, en_last;
  int done_cycle, busy_low, idle_txd_bad, cap_len;
  logic [7:0] cap [0:2047];
  logic post_busy, post_done, aborted;
  logic [2:0] ab_before;
  logic [11:0] ab_after;

  logic [7:0] exp_b [0:2047];
  int exp_len;
  logic [31:0] exp_fcs;

  task automatic fill_mem(input int mul);
    for (int i = 0; i < 2048; i++) mem[i] = 8'((i * mul + 3) & 255);
  endtask

  task automatic build_expected(input int n, input int pad_to);
    logic [31:0] c;
    logic [7:0] b;
    int plen;
    plen = (n > pad_to) ? n : pad_to;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < 7; k++) exp_b[k] = 8'h55;
    exp_b[7] = 8'hD5;
    for (int k = 0; k < plen; k++) begin
      b = (k < n) ? mem[k] : 8'h00;
      exp_b[8 + k] = b;
      c = c ^ {24'h0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    exp_fcs = ~c;
    for (int k = 0; k < 4; k++) exp_b[8 + plen + k] = exp_fcs[8*k +: 8];
    exp_len = 12 + plen;
  endtask

  // Drives one start at the current negedge; cycle i is sampled at the i-th
  // negedge after the start edge. Returns at the negedge after tx_done.
  task automatic run_frame(input logic [15:0] n, input bit spam, input int abort_at);
    tx_byte_num = n;
    tx_start_en = 1'b1;
    @(posedge rd_clk);
    #1 tx_start_en = 1'b0;
    req_cnt = 0; req_first = -1; req_last = -1;
    en_cnt = 0; en_first = -1; en_last = -1;
    done_cycle = -1; busy_low = 0; idle_txd_bad = 0; cap_len = 0;
    aborted = 1'b0;
    for (int i = 0; i < 2200; i++) begin
      @(negedge rd_clk);
      if (i == abort_at) begin
        ab_before = {gmii_tx_en, tx_req, tx_busy};
        rst_n = 1'b0;
        #1;
        ab_after = {gmii_tx_en, tx_req, tx_busy, tx_done, gmii_txd};
        aborted = 1'b1;
        break;
      end
      if (tx_req) begin
        req_cnt++;
        if (req_first < 0) req_first = i;
        req_last = i;
      end
      if (gmii_tx_en) begin
        en_cnt++;
        if (en_first < 0) en_first = i;
        en_last = i;
        if (cap_len < 2048) begin
          cap[cap_len] = gmii_txd;
          cap_len++;
        end
      end else if (gmii_txd !== 8'h00) begin
        idle_txd_bad++;
      end
      if (tx_busy !== 1'b1) busy_low++;
      tx_start_en = spam && ((i % 97) == 50);
      if (tx_done === 1'b1) begin
        done_cycle = i;
        break;
      end
    end
    if (aborted) begin
      tx_start_en = 1'b0;
      return;
    end
    tx_start_en = spam;
    @(negedge rd_clk);
    tx_start_en = 1'b0;
    post_busy = tx_busy;
    post_done = tx_done;
  endtask

  task automatic check_frame_bytes(input string name);
    int bad, first_bad;
    bad = 0; first_bad = -1;
    for (int k = 0; k < exp_len; k++) begin
      if (cap[k] !== exp_b[k]) begin
        if (first_bad < 0) first_bad = k;
        bad++;
      end
    end
    checks++;
    if (cap_len != exp_len || bad != 0) begin
      errors++;
      $display("FAIL %s: captured %0d bytes (%0d differ, first at %0d), required %0d bytes",
               name, cap_len, bad, first_bad, exp_len);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge rd_clk);
    checks++;
    if ({gmii_tx_en, gmii_txd, tx_req, tx_done, tx_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: en=%b txd=%h req=%b done=%b busy=%b, required all 0",
               gmii_tx_en, gmii_txd, tx_req, tx_done, tx_busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge rd_clk);
  endtask

  task automatic test_basic_crc();
    for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);
    build_expected(9, 0);
    run_frame(16'd9, 1'b0, -1);
    checks++;
    if ({req_first, req_last, req_cnt} !== {32'sd7, 32'sd15, 32'sd9}) begin
      errors++;
      $display("FAIL basic_req: first=%0d last=%0d count=%0d, required 7 15 9", req_first, req_last, req_cnt);
    end
    checks++;
    if ({en_first, en_last, en_cnt} !== {32'sd1, 32'sd21, 32'sd21}) begin
      errors++;
      $display("FAIL basic_tx_en: first=%0d last=%0d count=%0d, required 1 21 21", en_first, en_last, en_cnt);
    end
    check_frame_bytes("basic_frame");
    checks++;
    if ({cap[20], cap[19], cap[18], cap[17]} !== 32'hCBF4_3926) begin
      errors++;
      $display("FAIL basic_fcs: got %h %h %h %h, required 26 39 f4 cb", cap[17], cap[18], cap[19], cap[20]);
    end
    checks++;
    if (done_cycle != 33 || post_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: cycle=%0d next=%b, required cycle 33 single pulse", done_cycle, post_done);
    end
    checks++;
    if (busy_low != 0 || post_busy !== 1'b0 || idle_txd_bad != 0) begin
      errors++;
      $display("FAIL basic_busy_idle: busy_low=%0d busy_after=%b idle_txd_bad=%0d, required 0 0 0",
               busy_low, post_busy, idle_txd_bad);
    end
  endtask

  task automatic test_back_to_back();
    fill_mem(7);
    build_expected(1024, 0);
    for (int f = 0; f < 2; f++) begin
      run_frame(16'd1024, (f == 0), -1);
      checks++;
      if (req_cnt != 1024 || req_first != 7 || en_first != 1 || en_cnt != 1036) begin
        errors++;
        $display("FAIL b2b_timing[%0d]: req=%0d req_first=%0d en_first=%0d en=%0d, required 1024 7 1 1036",
                 f, req_cnt, req_first, en_first, en_cnt);
      end
      check_frame_bytes("b2b_frame");
      checks++;
      if (done_cycle != 1048 || post_busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_done[%0d]: cycle=%0d busy_after=%b, required 1048 0", f, done_cycle, post_busy);
      end
    end
    begin
      int act;
      act = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge rd_clk);
        if (gmii_tx_en || tx_busy || tx_req) act++;
      end
      checks++;
      if (act != 0) begin
        errors++;
        $display("FAIL b2b_no_extra_frame: %0d active cycles after last frame, required 0", act);
      end
    end
  endtask

  task automatic test_zero_len();
    run_frame(16'd0, 1'b0, -1);
    checks++;
    if (req_cnt != 0 || en_cnt != 0 || busy_low != 0) begin
      errors++;
      $display("FAIL zero_len: req=%0d en=%0d busy_low=%0d, required 0 0 0", req_cnt, en_cnt, busy_low);
    end
    checks++;
    if (done_cycle != 12 || post_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: cycle=%0d busy_after=%b, required 12 0", done_cycle, post_busy);
    end
  endtask

  task automatic test_clamp();
    fill_mem(13);
    build_expected(1500, 0);
    run_frame(16'd2000, 1'b0, -1);
    checks++;
    if (req_cnt != 1500 || en_cnt != 1512 || done_cycle != 1524) begin
      errors++;
      $display("FAIL clamp_counts: req=%0d en=%0d done=%0d, required 1500 1512 1524", req_cnt, en_cnt, done_cycle);
    end
    check_frame_bytes("clamp_frame");
    checks++;
    if ({cap[1511], cap[1510], cap[1509], cap[1508]} !== exp_fcs) begin
      errors++;
      $display("FAIL clamp_fcs: got %h%h%h%h, required %h", cap[1511], cap[1510], cap[1509], cap[1508], exp_fcs);
    end
  endtask

  task automatic test_pad();
    fill_mem(29);
`ifdef GMII_FRAME_TX_PAD_EN
    build_expected(10, 46);
    run_frame(16'd10, 1'b0, -1);
    checks++;
    if (req_cnt != 10 || en_cnt != 58 || done_cycle != 70) begin
      errors++;
      $display("FAIL pad_counts: req=%0d en=%0d done=%0d, required 10 58 70", req_cnt, en_cnt, done_cycle);
    end
`else
    build_expected(10, 0);
    run_frame(16'd10, 1'b0, -1);
    checks++;
    if (req_cnt != 10 || en_cnt != 22 || done_cycle != 34) begin
      errors++;
      $display("FAIL nopad_counts: req=%0d en=%0d done=%0d, required 10 22 34", req_cnt, en_cnt, done_cycle);
    end
`endif
    check_frame_bytes("short_frame");
  endtask

  task automatic test_reset_mid_frame();
    fill_mem(5);
    run_frame(16'd1024, 1'b0, 509);
    checks++;
    if (!aborted || ab_before !== 3'b111) begin
      errors++;
      $display("FAIL midreset_before: aborted=%b en/req/busy=%b, required 1 111", aborted, ab_before);
    end
    checks++;
    if (ab_after !== 12'h000) begin
      errors++;
      $display("FAIL midreset_async: en/req/busy/done/txd=%h, required 000", ab_after);
    end
    repeat (3) @(negedge rd_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge rd_clk);
    fill_mem(11);
    build_expected(64, 0);
    run_frame(16'd64, 1'b0, -1);
`ifdef GMII_FRAME_TX_PAD_EN
    checks++;
    if (req_cnt != 64 || en_cnt != 76 || done_cycle != 88) begin
`else
    checks++;
    if (req_cnt != 64 || en_cnt != 76 || done_cycle != 88) begin
`endif
      errors++;
      $display("FAIL midreset_recover: req=%0d en=%0d done=%0d, required 64 76 88", req_cnt, en_cnt, done_cycle);
    end
    check_frame_bytes("midreset_frame");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_crc();
    test_zero_len();
    test_back_to_back();
    test_clamp();
    test_pad();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
